// File: rtl/rshp_pkg.sv
// Shared defaults, beat tag and FSM state type for the reshaper read-side controller.
package rshp_pkg;

    localparam int RSHP_DW_DEF  = 512;
    localparam int RSHP_LW_DEF  = 16;
    // Wide enough for chunk values 1..BB with DW up to 1024.
    localparam int RSHP_CHUNK_W = 8;

    typedef struct packed {
        logic [RSHP_CHUNK_W-1:0] chunk;
        logic                    eol;
        logic                    eoc;
    } rshp_beat_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } rshp_rd_st_e;

endpackage

// File: rtl/rshp_rdq.sv
// Circular output queue holding returned FIFO beats and their tags; head is
// presented combinationally, push and pop may occur in the same cycle.
module rshp_rdq
    import rshp_pkg::*;
#(
    parameter int DW     = RSHP_DW_DEF,
    parameter int QDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_push,
    input  logic [DW-1:0]                i_push_data,
    input  rshp_beat_tag_t               i_push_tag,
    input  logic                         i_pop,
    output logic [$clog2(QDEPTH+1)-1:0]  o_occ,
    output logic                         o_empty,
    output logic [DW-1:0]                o_head_data,
    output rshp_beat_tag_t               o_head_tag
);

    localparam int OW = $clog2(QDEPTH+1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [DW-1:0]   r_data [QDEPTH];
    rshp_beat_tag_t  r_tag  [QDEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [OW-1:0]   r_occ;
    logic            w_do_pop;

    assign w_do_pop    = i_pop && (r_occ != '0);
    assign o_occ       = r_occ;
    assign o_empty     = (r_occ == '0);
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_tag  = r_tag[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(QDEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(QDEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_tag[r_wr_ptr]  <= i_push_tag;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(i_push && !w_do_pop && (r_occ == OW'(QDEPTH))));
`endif

endmodule

// File: rtl/rshp_rdctrl.sv
// Reshaper read-side controller: issues sized FIFO reads per command, queues the
// returned beats and streams them out. Optional macro RSHP_RDCTRL_ZMASK_EN zeroes unused bytes.
module rshp_rdctrl
    import rshp_pkg::*;
#(
    parameter int DW     = RSHP_DW_DEF,
    parameter int LW     = RSHP_LW_DEF,
    parameter int QDEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic [LW-1:0]           cmd_linebyte,
    input  logic [LW-1:0]           cmd_nline,
    output logic                    cmd_done,
    output logic                    ffrreq,
    output logic [$clog2(DW/8):0]   ffrbyte,
    input  logic [DW-1:0]           ffrdata,
    input  logic                    ffrvld,
    input  logic [$clog2(DW/4):0]   ffvbyte,
    output logic                    o_vld,
    input  logic                    o_rdy,
    output logic [DW-1:0]           o_data,
    output logic [$clog2(DW/8):0]   o_byte,
    output logic                    o_eol,
    output logic                    o_eoc
);

    // state    | meaning
    // ST_IDLE  | cmd_rdy high, waiting for a command
    // ST_RUN   | issuing reads until the last beat of the command is issued
    // ST_DRAIN | no issues; waiting for the eoc beat to leave the queue

    localparam int BB = DW/8;
    localparam int BW = $clog2(BB) + 1;
    localparam int OW = $clog2(QDEPTH+1);

    rshp_rd_st_e     r_state;
    rshp_rd_st_e     w_state_nxt;
    logic [LW-1:0]   r_linebyte;
    logic [LW-1:0]   r_rem_byte;
    logic [LW-1:0]   r_rem_line;
    logic            r_inflight;
    logic            r_zdone;
    rshp_beat_tag_t  r_tag_pipe;

    logic [LW-1:0]   w_chunk;
    rshp_beat_tag_t  w_issue_tag;
    logic            w_credit_ok;
    logic            w_issue;
    logic            w_line_end;
    logic            w_cmd_last;
    logic            w_accept;
    logic            w_zero_cmd;
    logic            w_pop;
    logic            w_eoc_pop;
    logic [OW-1:0]   w_occ;
    logic            w_empty;
    logic [DW-1:0]   w_push_data;
    logic [DW-1:0]   w_head_data;
    rshp_beat_tag_t  w_head_tag;

    // Pops in the current cycle are deliberately not credited.
    assign w_chunk     = (r_rem_byte < LW'(BB)) ? r_rem_byte : LW'(BB);
    assign w_credit_ok = (32'(w_occ) + 32'(r_inflight)) < QDEPTH;
    assign w_issue     = (r_state == ST_RUN) && (32'(ffvbyte) >= 32'(w_chunk)) && w_credit_ok;
    assign w_line_end  = (r_rem_byte == w_chunk);
    assign w_cmd_last  = w_line_end && (r_rem_line == LW'(1));
    assign w_accept    = (r_state == ST_IDLE) && cmd_vld;
    assign w_zero_cmd  = (cmd_linebyte == '0) || (cmd_nline == '0);
    assign w_pop       = o_vld && o_rdy;
    assign w_eoc_pop   = w_pop && w_head_tag.eoc;
    assign w_issue_tag = '{chunk: RSHP_CHUNK_W'(w_chunk), eol: w_line_end, eoc: w_cmd_last};

    assign cmd_rdy  = (r_state == ST_IDLE);
    assign ffrreq   = w_issue;
    assign ffrbyte  = w_issue ? BW'(w_chunk) : '0;
    assign cmd_done = r_zdone || ((r_state == ST_DRAIN) && w_eoc_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && !w_zero_cmd) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_issue && w_cmd_last)   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_eoc_pop)               w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_linebyte <= '0;
            r_rem_byte <= '0;
            r_rem_line <= '0;
            r_inflight <= 1'b0;
            r_zdone    <= 1'b0;
            r_tag_pipe <= '0;
        end else begin
            r_zdone    <= w_accept && w_zero_cmd;
            r_inflight <= w_issue;
            if (w_accept) begin
                r_linebyte <= cmd_linebyte;
                r_rem_byte <= cmd_linebyte;
                r_rem_line <= cmd_nline;
            end else if (w_issue) begin
                if (w_line_end) begin
                    r_rem_byte <= r_linebyte;
                    r_rem_line <= r_rem_line - LW'(1);
                end else begin
                    r_rem_byte <= r_rem_byte - w_chunk;
                end
            end
            if (w_issue) begin
                r_tag_pipe <= w_issue_tag;
            end
        end
    end

`ifdef RSHP_RDCTRL_ZMASK_EN
    assign w_push_data = ffrdata & ~({DW{1'b1}} << {r_tag_pipe.chunk, 3'b000});
`else
    assign w_push_data = ffrdata;
`endif

    rshp_rdq #(
        .DW     (DW),
        .QDEPTH (QDEPTH)
    ) u_rdq (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (ffrvld && r_inflight),
        .i_push_data (w_push_data),
        .i_push_tag  (r_tag_pipe),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_empty     (w_empty),
        .o_head_data (w_head_data),
        .o_head_tag  (w_head_tag)
    );

    assign o_vld  = !w_empty;
    assign o_data = o_vld ? w_head_data : '0;
    assign o_byte = o_vld ? BW'(w_head_tag.chunk) : '0;
    assign o_eol  = o_vld && w_head_tag.eol;
    assign o_eoc  = o_vld && w_head_tag.eoc;

`ifndef SYNTHESIS
    a_vld_has_req: assert property (@(posedge clk) disable iff (!reset_n) ffrvld |-> r_inflight);
`endif

endmodule

// File: tb/tb_rshp_rdctrl.sv
// Bench for rshp_rdctrl: behavioural FIFO environment plus a line/chunk reference model.
// Honors RSHP_RDCTRL_ZMASK_EN when checking bytes above o_byte.
module tb_rshp_rdctrl;

    localparam int DW     = 512;
    localparam int LW     = 16;
    localparam int QDEPTH = 4;
    localparam int BB     = DW/8;
    localparam int BW     = $clog2(BB) + 1;
    localparam int VW     = $clog2(2*BB) + 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cmd_vld = 1'b0;
    logic            cmd_rdy;
    logic [LW-1:0]   cmd_linebyte = '0;
    logic [LW-1:0]   cmd_nline = '0;
    logic            cmd_done;
    logic            ffrreq;
    logic [BW-1:0]   ffrbyte;
    logic [DW-1:0]   ffrdata = '0;
    logic            ffrvld = 1'b0;
    logic [VW-1:0]   ffvbyte = '0;
    logic            o_vld;
    logic            o_rdy = 1'b0;
    logic [DW-1:0]   o_data;
    logic [BW-1:0]   o_byte;
    logic            o_eol;
    logic            o_eoc;

    rshp_rdctrl #(.DW(DW), .LW(LW), .QDEPTH(QDEPTH)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_vld      (cmd_vld),
        .cmd_rdy      (cmd_rdy),
        .cmd_linebyte (cmd_linebyte),
        .cmd_nline    (cmd_nline),
        .cmd_done     (cmd_done),
        .ffrreq       (ffrreq),
        .ffrbyte      (ffrbyte),
        .ffrdata      (ffrdata),
        .ffrvld       (ffrvld),
        .ffvbyte      (ffvbyte),
        .o_vld        (o_vld),
        .o_rdy        (o_rdy),
        .o_data       (o_data),
        .o_byte       (o_byte),
        .o_eol        (o_eol),
        .o_eoc        (o_eoc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            nb;
        bit            eol;
        bit            eoc;
    } beat_t;

    beat_t         obs_q[$];
    beat_t         exp_q[$];
    int            obs_chunks[$];
    int            exp_chunks[$];
    byte unsigned  src_q[$];
    byte unsigned  fifo_q[$];
    byte unsigned  pend_bytes[$];
    bit            pend_req = 0;
    bit            cmd_pend = 0;
    int            fifo_cap = 2*BB;
    int            rdy_pct = 100;
    int            cyc = 0;
    int            n_issue, n_pop, max_out, viol, done_cnt;
    int            acc_cyc, done_cyc, eoc_pop_cyc, first_req_cyc, first_pop_cyc, last_pop_cyc;
    int            total = 0;
    int            bad = 0;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Bytes the bench holds the DUT accountable for in o_data.
    function automatic logic [DW-1:0] got_data(input beat_t b);
`ifdef RSHP_RDCTRL_ZMASK_EN
        return b.data;
`else
        logic [DW-1:0] m = '0;
        for (int i = 0; i < b.nb; i++) m[i*8 +: 8] = 8'hFF;
        return b.data & m;
`endif
    endfunction

    // Reference: every line is cut into min(bytes left in line, BB) pieces, in stream order.
    task automatic build_exp(input int lb, input int nl, input byte unsigned s[$]);
        beat_t b;
        int    n;
        exp_q.delete();
        exp_chunks.delete();
        if (lb == 0 || nl == 0) return;
        for (int l = 0; l < nl; l++) begin
            for (int off = 0; off < lb; off += n) begin
                n = (lb - off < BB) ? lb - off : BB;
                b.data = '0;
                for (int i = 0; i < n; i++) b.data[i*8 +: 8] = s[l*lb + off + i];
                b.nb  = n;
                b.eol = (off + n == lb);
                b.eoc = b.eol && (l == nl - 1);
                exp_q.push_back(b);
                exp_chunks.push_back(n);
            end
        end
    endtask

    task automatic cycle();
        beat_t b;
        @(negedge clk);
        cyc++;
        ffrdata = rand_word();
        ffrvld  = pend_req;
        if (pend_req) begin
            for (int i = 0; i < pend_bytes.size(); i++) ffrdata[i*8 +: 8] = pend_bytes[i];
        end
        while (fifo_q.size() < fifo_cap && src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
        ffvbyte = VW'(fifo_q.size());
        o_rdy   = ($urandom_range(99) < rdy_pct);
        cmd_vld = cmd_pend;
        #1;
        if (cmd_vld && cmd_rdy) begin
            cmd_pend = 0;
            acc_cyc  = cyc;
        end
        pend_req = ffrreq;
        pend_bytes.delete();
        if (ffrreq) begin
            n_issue++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            obs_chunks.push_back(int'(ffrbyte));
            if (int'(ffrbyte) > fifo_q.size() || ffrbyte == '0) viol++;
            else for (int i = 0; i < int'(ffrbyte); i++) pend_bytes.push_back(fifo_q.pop_front());
        end
        if (o_vld && o_rdy) begin
            b.data = o_data;
            b.nb   = int'(o_byte);
            b.eol  = o_eol;
            b.eoc  = o_eoc;
            obs_q.push_back(b);
            n_pop++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (o_eoc) eoc_pop_cyc = cyc;
        end
        if (n_issue - n_pop > max_out) max_out = n_issue - n_pop;
        if (cmd_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic start_cmd(input int lb, input int nl);
        byte unsigned s[$];
        for (int i = 0; i < lb*nl; i++) s.push_back(8'($urandom));
        src_q = s;
        build_exp(lb, nl, s);
        obs_q.delete();
        obs_chunks.delete();
        n_issue = 0; n_pop = 0; max_out = 0; viol = 0; done_cnt = 0;
        acc_cyc = -1; done_cyc = -1; eoc_pop_cyc = -1;
        first_req_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
        cmd_linebyte = LW'(lb);
        cmd_nline    = LW'(nl);
        cmd_pend     = 1;
    endtask

    task automatic finish_cmd(input int budget);
        int k = 0;
        while (!(acc_cyc >= 0 && done_cnt > 0 && obs_q.size() >= exp_q.size()) && k < budget) begin
            cycle();
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL cmd_timeout: got done=%0d beats=%0d, want done=1 beats=%0d",
                     done_cnt, obs_q.size(), exp_q.size());
        end
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ffvbyte = VW'(2*BB);
        cmd_vld = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({cmd_rdy, cmd_done, ffrreq, o_vld, o_eol, o_eoc} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 100000", {cmd_rdy, cmd_done, ffrreq, o_vld, o_eol, o_eoc});
        end
        total++;
        if (ffrbyte !== '0 || o_byte !== '0) begin
            bad++;
            $display("FAIL reset_counts: got ffrbyte=%0d o_byte=%0d want 0 0", ffrbyte, o_byte);
        end
        total++;
        if (o_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", o_data[63:0]);
        end
        cmd_vld = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        fifo_cap = BB;
        rdy_pct  = 100;
        start_cmd(64, 1);
        finish_cmd(200);
        total++;
        if (obs_chunks.size() != 1 || obs_chunks[0] != 64) begin
            bad++;
            $display("FAIL basic_ffrbyte: got %0d reads first=%0d want 1 read of 64",
                     obs_chunks.size(), (obs_chunks.size() > 0) ? obs_chunks[0] : -1);
        end
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL basic_beats: got %0d want 1", obs_q.size());
        end else if (obs_q[0].nb != 64 || !obs_q[0].eol || !obs_q[0].eoc || got_data(obs_q[0]) !== exp_q[0].data) begin
            bad++;
            $display("FAIL basic_beat: got byte=%0d eol=%0d eoc=%0d want 64 1 1 with matching data",
                     obs_q[0].nb, obs_q[0].eol, obs_q[0].eoc);
        end
        total++;
        if (done_cnt != 1 || done_cyc != eoc_pop_cyc) begin
            bad++;
            $display("FAIL basic_done: got count=%0d at cyc %0d want 1 at eoc pop cyc %0d", done_cnt, done_cyc, eoc_pop_cyc);
        end
    endtask

    task automatic test_nonmult();
        int want_ch[6]  = '{64, 64, 22, 64, 64, 22};
        bit want_eol[6] = '{0, 0, 1, 0, 0, 1};
        bit want_eoc[6] = '{0, 0, 0, 0, 0, 1};
        fifo_cap = 2*BB;
        rdy_pct  = 100;
        start_cmd(150, 2);
        finish_cmd(300);
        total++;
        if (obs_chunks.size() != 6 || obs_q.size() != 6) begin
            bad++;
            $display("FAIL nonmult_count: got reads=%0d beats=%0d want 6 6", obs_chunks.size(), obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (obs_chunks[i] != want_ch[i] || obs_q[i].nb != want_ch[i] || obs_q[i].eol != want_eol[i] ||
                    obs_q[i].eoc != want_eoc[i] || got_data(obs_q[i]) !== exp_q[i].data) begin
                    bad++;
                    $display("FAIL nonmult_beat%0d: got rd=%0d byte=%0d eol=%0d eoc=%0d want %0d %0d %0d %0d",
                             i, obs_chunks[i], obs_q[i].nb, obs_q[i].eol, obs_q[i].eoc,
                             want_ch[i], want_ch[i], want_eol[i], want_eoc[i]);
                end
            end
        end
    endtask

    task automatic test_starve();
        fifo_cap = 40;
        rdy_pct  = 100;
        start_cmd(64, 1);
        repeat (10) cycle();
        total++;
        if (acc_cyc < 0 || n_issue != 0) begin
            bad++;
            $display("FAIL starve_hold: got accepted=%0d reads=%0d want 1 0", acc_cyc >= 0, n_issue);
        end
        fifo_cap = 2*BB;
        cycle();
        total++;
        if (n_issue != 1 || first_req_cyc != cyc) begin
            bad++;
            $display("FAIL starve_release: got reads=%0d first at %0d want 1 at %0d", n_issue, first_req_cyc, cyc);
        end
        finish_cmd(100);
        total++;
        if (viol != 0 || obs_q.size() != 1 || got_data(obs_q[0]) !== exp_q[0].data) begin
            bad++;
            $display("FAIL starve_data: got viol=%0d beats=%0d want 0 1 matching", viol, obs_q.size());
        end
    endtask

    task automatic test_backpressure();
        fifo_cap = 2*BB;
        rdy_pct  = 0;
        start_cmd(128, 4);
        repeat (20) cycle();
        total++;
        if (n_issue != QDEPTH || n_pop != 0 || max_out > QDEPTH) begin
            bad++;
            $display("FAIL bp_stall: got reads=%0d pops=%0d max_out=%0d want %0d 0 <=%0d",
                     n_issue, n_pop, max_out, QDEPTH, QDEPTH);
        end
        rdy_pct = 100;
        finish_cmd(200);
        total++;
        if (obs_q.size() != 8 || max_out > QDEPTH || done_cnt != 1) begin
            bad++;
            $display("FAIL bp_count: got beats=%0d max_out=%0d done=%0d want 8 <=%0d 1",
                     obs_q.size(), max_out, done_cnt, QDEPTH);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (obs_q[i].nb != exp_q[i].nb || obs_q[i].eol != exp_q[i].eol ||
                    obs_q[i].eoc != exp_q[i].eoc || got_data(obs_q[i]) !== exp_q[i].data) begin
                    bad++;
                    $display("FAIL bp_beat%0d: got byte=%0d eol=%0d eoc=%0d want %0d %0d %0d",
                             i, obs_q[i].nb, obs_q[i].eol, obs_q[i].eoc, exp_q[i].nb, exp_q[i].eol, exp_q[i].eoc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        fifo_cap = 2*BB;
        rdy_pct  = 100;
        start_cmd(512, 1);
        finish_cmd(200);
        total++;
        if (first_req_cyc - acc_cyc != 1 || first_pop_cyc - acc_cyc != 3) begin
            bad++;
            $display("FAIL b2b_latency: got req=+%0d pop=+%0d want +1 +3", first_req_cyc - acc_cyc, first_pop_cyc - acc_cyc);
        end
        total++;
        if (obs_q.size() != 8 || last_pop_cyc - first_pop_cyc != 7) begin
            bad++;
            $display("FAIL b2b_rate: got beats=%0d span=%0d want 8 7", obs_q.size(), last_pop_cyc - first_pop_cyc);
        end
    endtask

    task automatic test_zero();
        int cfg_lb[2] = '{0, 9};
        int cfg_nl[2] = '{5, 0};
        fifo_cap = 2*BB;
        rdy_pct  = 100;
        for (int t = 0; t < 2; t++) begin
            start_cmd(cfg_lb[t], cfg_nl[t]);
            fifo_q.push_back(8'hA5);
            repeat (6) cycle();
            total++;
            if (done_cnt != 1 || done_cyc != acc_cyc + 1 || acc_cyc < 0) begin
                bad++;
                $display("FAIL zero%0d_done: got count=%0d at +%0d want 1 at +1", t, done_cnt, done_cyc - acc_cyc);
            end
            total++;
            if (n_issue != 0 || cmd_rdy !== 1'b1 || n_pop != 0) begin
                bad++;
                $display("FAIL zero%0d_idle: got reads=%0d rdy=%0b pops=%0d want 0 1 0", t, n_issue, cmd_rdy, n_pop);
            end
            fifo_q.delete();
        end
    endtask

    task automatic test_midreset();
        int k = 0;
        fifo_cap = 2*BB;
        rdy_pct  = 0;
        start_cmd(64, 4);
        while (n_issue < 3 && k < 20) begin
            cycle();
            k++;
        end
        total++;
        if (o_vld !== 1'b1 || n_issue < 3) begin
            bad++;
            $display("FAIL mrst_pre: got o_vld=%0b reads=%0d want 1 >=3", o_vld, n_issue);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({cmd_rdy, cmd_done, ffrreq, o_vld, o_eol, o_eoc} !== 6'b100000 || ffrbyte !== '0 ||
            o_byte !== '0 || o_data !== '0) begin
            bad++;
            $display("FAIL mrst_async: got flags=%b ffrbyte=%0d o_byte=%0d want 100000 0 0",
                     {cmd_rdy, cmd_done, ffrreq, o_vld, o_eol, o_eoc}, ffrbyte, o_byte);
        end
        pend_req = 0;
        cmd_pend = 0;
        fifo_q.delete();
        src_q.delete();
        ffrvld = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rdy_pct = 100;
        start_cmd(100, 1);
        finish_cmd(200);
        total++;
        if (obs_q.size() != 2 || done_cnt != 1) begin
            bad++;
            $display("FAIL mrst_after: got beats=%0d done=%0d want 2 1", obs_q.size(), done_cnt);
        end else if (obs_q[1].nb != 36 || !obs_q[1].eoc || got_data(obs_q[0]) !== exp_q[0].data ||
                     got_data(obs_q[1]) !== exp_q[1].data) begin
            bad++;
            $display("FAIL mrst_beats: got last byte=%0d eoc=%0d want 36 1 with matching data", obs_q[1].nb, obs_q[1].eoc);
        end
    endtask

    task automatic test_random();
        int lb, nl;
        for (int r = 0; r < 6; r++) begin
            lb       = $urandom_range(300, 1);
            nl       = $urandom_range(3, 1);
            fifo_cap = $urandom_range(2*BB, BB);
            rdy_pct  = $urandom_range(100, 30);
            start_cmd(lb, nl);
            finish_cmd(4000);
            total++;
            if (obs_q.size() != exp_q.size() || obs_chunks.size() != exp_chunks.size() || done_cnt != 1 ||
                viol != 0 || max_out > QDEPTH) begin
                bad++;
                $display("FAIL rand%0d_shape: got beats=%0d reads=%0d done=%0d viol=%0d max_out=%0d want %0d %0d 1 0 <=%0d",
                         r, obs_q.size(), obs_chunks.size(), done_cnt, viol, max_out,
                         exp_q.size(), exp_chunks.size(), QDEPTH);
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    total++;
                    if (obs_chunks[i] != exp_chunks[i] || obs_q[i].nb != exp_q[i].nb || obs_q[i].eol != exp_q[i].eol ||
                        obs_q[i].eoc != exp_q[i].eoc || got_data(obs_q[i]) !== exp_q[i].data) begin
                        bad++;
                        $display("FAIL rand%0d_beat%0d: got rd=%0d byte=%0d eol=%0d eoc=%0d want %0d %0d %0d %0d",
                                 r, i, obs_chunks[i], obs_q[i].nb, obs_q[i].eol, obs_q[i].eoc,
                                 exp_chunks[i], exp_q[i].nb, exp_q[i].eol, exp_q[i].eoc);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nonmult();
        test_starve();
        test_backpressure();
        test_back_to_back();
        test_zero();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
